// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the BRAM port A arbiter.
// Latency presets match the two BRAM output-register configurations.
package bram_arb_pkg;

  localparam int HIGH_PERFORMANCE = 3;
  localparam int LOW_LATENCY      = 1;

  // Tags are sized for the largest supported requester count.
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef struct packed {
    logic               valid;
    logic [MAX_REQ-1:0] id;
  } rd_tag_t;

  // OR-reduction encoder: exact for one-hot input, 0 for all-zero input.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin grant, combinational from req; pointer register moves past the winner.
// Zero-cycle grant; pointer only advances when the caller reports an accepted grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_next;
  logic [SUM_W-1:0] sum;
  logic [PTR_W-1:0] idx;
  logic             found;

  // Scan requesters starting at ptr; the first asserted one wins.
  always_comb begin
    grant    = '0;
    ptr_next = ptr;
    sum      = '0;
    idx      = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SUM_W'(i);
      if (sum >= SUM_W'(NUM_REQ)) begin
        sum = sum - SUM_W'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance && found) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares BRAM port A among NUM_REQ requesters, one single-word access per clock.
// Accept at T, BRAM enable at T+1, read response at T+1+READ_LATENCY; no response backpressure.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_WIDTH   = 18,
  parameter  int BRAM_DEPTH   = 2048,
  parameter  int READ_LATENCY = HIGH_PERFORMANCE,
  localparam int ADDR_W       = $clog2(BRAM_DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic [ADDR_W-1:0]              bram_addra,
  output logic [DATA_WIDTH-1:0]          bram_dina,
  output logic                           bram_ena,
  output logic                           bram_wea,
  output logic                           bram_rsta,
  output logic                           bram_regcea,
  input  logic [DATA_WIDTH-1:0]          bram_douta,
  output logic                           busy
);

  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic [MAX_REQ-1:0]    grant_pad;
  logic [IDX_W-1:0]      grant_idx;
  logic [ADDR_W-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_we;
  logic [MAX_REQ-1:0]    id_mask;
  logic                  rsp_live;

  rd_tag_t pipe [READ_LATENCY];
  rd_tag_t rsp_tag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  // No grant is offered while reset is held, even with valid requests.
  assign req_ready = rst_n ? grant : '0;
  assign accept    = |req_ready;

  assign bram_rsta   = ~rst_n;
  assign bram_regcea = 1'b1;
  assign rsp_data    = bram_douta;

  always_comb begin
    grant_pad                = '0;
    grant_pad[NUM_REQ-1:0]   = grant;
    grant_idx                = onehot_to_idx(grant_pad);
    sel_addr                 = '0;
    sel_wdata                = '0;
    sel_we                   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_we    = req_we[i];
      end
    end
  end

  // Issue stage: address/data hold between accesses so port A toggles only when used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bram_ena   <= 1'b0;
      bram_wea   <= 1'b0;
      bram_addra <= '0;
      bram_dina  <= '0;
    end else begin
      bram_ena <= accept;
      bram_wea <= accept & sel_we;
      if (accept) begin
        bram_addra <= sel_addr;
        bram_dina  <= sel_wdata;
      end
    end
  end

  // Tags enter alongside the issue registers; the extra rsp_tag stage lines the
  // strobe up with douta, which trails the enable by READ_LATENCY cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe[k] <= '0;
      end
      rsp_tag <= '0;
    end else begin
      if (accept && !sel_we) begin
        pipe[0] <= '{valid: 1'b1, id: grant_pad};
      end else begin
        pipe[0] <= '0;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe[k] <= pipe[k-1];
      end
      rsp_tag <= pipe[READ_LATENCY-1];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < READ_LATENCY; k++) begin
      busy = busy | pipe[k].valid;
    end
  end

  // A tag naming a requester outside this instance never produces a strobe.
  always_comb begin
    id_mask                = '0;
    id_mask[NUM_REQ-1:0]   = '1;
    rsp_live               = rsp_tag.valid & ~|(rsp_tag.id & ~id_mask);
    rsp_valid              = rsp_live ? rsp_tag.id[NUM_REQ-1:0] : '0;
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Drives two arbiters (read latency 3 and 1) with shared requests against BRAM models,
// comparing every cycle to a scoreboard of accepted accesses plus directed literal cases.
module tb_bram_port_arbiter;

  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 18;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;

  bit [N-1:0]  rv;
  bit [N-1:0]  rwe;
  bit [AW-1:0] raddr [N];
  bit [DW-1:0] rwd   [N];

  always_comb begin
    req_valid = rv;
    req_we    = rwe;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = raddr[i];
      req_wdata[i*DW +: DW] = rwd[i];
    end
  end

  logic [N-1:0]  rdy_a, rspv_a, rdy_b, rspv_b;
  logic [DW-1:0] rspd_a, dina_a, douta_a, rspd_b, dina_b, douta_b;
  logic [AW-1:0] addra_a, addra_b;
  logic          ena_a, wea_a, rsta_a, regcea_a, busy_a;
  logic          ena_b, wea_b, rsta_b, regcea_b, busy_b;

  bram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BRAM_DEPTH(2048), .READ_LATENCY(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_a), .rsp_data(rspd_a),
    .bram_addra(addra_a), .bram_dina(dina_a), .bram_ena(ena_a), .bram_wea(wea_a),
    .bram_rsta(rsta_a), .bram_regcea(regcea_a), .bram_douta(douta_a), .busy(busy_a));

  bram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BRAM_DEPTH(2048), .READ_LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rspv_b), .rsp_data(rspd_b),
    .bram_addra(addra_b), .bram_dina(dina_b), .bram_ena(ena_b), .bram_wea(wea_b),
    .bram_rsta(rsta_b), .bram_regcea(regcea_b), .bram_douta(douta_b), .busy(busy_b));

  // Read-first BRAM models; rsta clears only the output registers.
  bit [DW-1:0] mem_a [2048];
  bit [DW-1:0] mem_b [2048];
  bit [DW-1:0] opipe_a [3];
  bit [DW-1:0] opipe_b;

  always @(posedge clk) begin
    if (rsta_a) begin
      for (int k = 0; k < 3; k++) opipe_a[k] <= '0;
    end else begin
      if (ena_a === 1'b1 && wea_a === 1'b0) opipe_a[0] <= mem_a[addra_a];
      for (int k = 1; k < 3; k++) opipe_a[k] <= opipe_a[k-1];
    end
    if (ena_a === 1'b1 && wea_a === 1'b1) mem_a[addra_a] <= dina_a;
  end
  assign douta_a = opipe_a[2];

  always @(posedge clk) begin
    if (rsta_b) opipe_b <= '0;
    else if (ena_b === 1'b1 && wea_b === 1'b0) opipe_b <= mem_b[addra_b];
    if (ena_b === 1'b1 && wea_b === 1'b1) mem_b[addra_b] <= dina_b;
  end
  assign douta_b = opipe_b;

  int nerr = 0;
  int nchk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: one entry per cycle recording what was accepted.
  int          cyc      = 0;
  int          last_rst = -1;
  int          mptr     = 0;
  bit          acc_vld  [64];
  bit          acc_we   [64];
  int          acc_id   [64];
  bit [AW-1:0] acc_addr [64];
  bit [DW-1:0] acc_data [64];
  bit [DW-1:0] shadow   [2048];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_read(input int t);
    return (t > last_rst) && (t >= 0) && acc_vld[t%64] && !acc_we[t%64];
  endfunction

  task automatic check_port(input int L, input string nm, input logic [N-1:0] rsp_v,
                            input logic [DW-1:0] rsp_d, input logic bz, input logic en,
                            input logic we, input logic [AW-1:0] ad);
    int t;
    bit [N-1:0] ev;
    bit eb;
    bit een;
    t  = cyc - 1 - L;
    ev = '0;
    if (is_read(t)) begin
      ev = N'(1 << acc_id[t%64]);
      chk({nm, "_rsp_data"}, 32'(rsp_d), 32'(acc_data[t%64]));
    end
    chk({nm, "_rsp_valid"}, 32'(rsp_v), 32'(ev));
    eb = 1'b0;
    for (int k = 1; k <= L; k++) if (is_read(cyc - k)) eb = 1'b1;
    chk({nm, "_busy"}, 32'(bz), 32'(eb));
    t   = cyc - 1;
    een = (t > last_rst) && (t >= 0) && acc_vld[t%64];
    chk({nm, "_ena"}, 32'(en), 32'(een));
    chk({nm, "_wea"}, 32'(we), 32'(een && acc_we[t%64]));
    if (een) chk({nm, "_addra"}, 32'(ad), 32'(acc_addr[t%64]));
  endtask

  always @(negedge clk) begin : model
    int g;
    bit [N-1:0] er;
    chk("rsta_a", 32'(rsta_a), 32'(!rst_n));
    if (!rst_n) begin
      last_rst = cyc;
      mptr     = 0;
      acc_vld[cyc%64] = 1'b0;
      chk("ready_in_reset_a", 32'(rdy_a), 32'd0);
      chk("ready_in_reset_b", 32'(rdy_b), 32'd0);
    end else begin
      g = -1;
      for (int i = 0; i < N; i++) begin
        if (g < 0 && req_valid[(mptr + i) % N]) g = (mptr + i) % N;
      end
      er = (g >= 0) ? N'(1 << g) : '0;
      chk("grant_a", 32'(rdy_a), 32'(er));
      chk("grant_b", 32'(rdy_b), 32'(er));
      check_port(3, "a", rspv_a, rspd_a, busy_a, ena_a, wea_a, addra_a);
      check_port(1, "b", rspv_b, rspd_b, busy_b, ena_b, wea_b, addra_b);
      acc_vld[cyc%64] = 1'b0;
      acc_we[cyc%64]  = 1'b0;
      if (g >= 0) begin
        acc_vld[cyc%64]  = 1'b1;
        acc_we[cyc%64]   = req_we[g];
        acc_id[cyc%64]   = g;
        acc_addr[cyc%64] = req_addr[g*AW +: AW];
        if (req_we[g]) shadow[req_addr[g*AW +: AW]] = req_wdata[g*DW +: DW];
        else           acc_data[cyc%64] = shadow[req_addr[g*AW +: AW]];
        mptr = (g + 1) % N;
      end
    end
  end

  // Per-cycle snapshot for directed literal checks.
  logic [N-1:0]  s_rdy, s_rspv_a, s_rspv_b;
  logic [DW-1:0] s_rspd_a, s_rspd_b, s_dina;
  logic [AW-1:0] s_addra;
  logic          s_busy_a, s_ena, s_wea, s_regcea;

  task automatic tick();
    @(negedge clk);
    s_rdy    = rdy_a;
    s_rspv_a = rspv_a;  s_rspd_a = rspd_a;  s_busy_a = busy_a;
    s_rspv_b = rspv_b;  s_rspd_b = rspd_b;
    s_ena    = ena_a;   s_wea    = wea_a;
    s_addra  = addra_a; s_dina   = dina_a;  s_regcea = regcea_a;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input bit we, input int addr, input bit [DW-1:0] d);
    bit got;
    got      = 1'b0;
    rv[r]    = 1'b1;
    rwe[r]   = we;
    raddr[r] = AW'(addr);
    rwd[r]   = d;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (s_rdy[r]) got = 1'b1;
    end
    chk("issue_accepted", 32'(got), 32'd1);
    rv[r] = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rv    = '1;
    rwe   = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("ready_held_low", 32'(s_rdy), 32'd0);
    end
    rst_n = 1'b1;
    rv    = '0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit [DW-1:0] ll_data [8];
    do_reset();

    tick();
    chk("rst_ready",   32'(s_rdy),    32'd0);
    chk("rst_rsp_v",   32'(s_rspv_a), 32'd0);
    chk("rst_busy",    32'(s_busy_a), 32'd0);
    chk("rst_ena",     32'(s_ena),    32'd0);
    chk("rst_wea",     32'(s_wea),    32'd0);
    chk("rst_addra",   32'(s_addra),  32'd0);
    chk("rst_dina",    32'(s_dina),   32'd0);
    chk("rst_rsp_dat", 32'(s_rspd_a), 32'd0);
    chk("regcea",      32'(s_regcea), 32'd1);

    // Single read of a preloaded word.
    issue(2, 1'b1, 5, 18'h2A5A0);
    rv[2] = 1'b1; rwe[2] = 1'b0; raddr[2] = 11'd5;
    tick();
    chk("single_grant", 32'(s_rdy), 32'h4);
    rv[2] = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      tick();
      chk("single_busy", 32'(s_busy_a), 32'd1);
    end
    tick();
    chk("single_rsp_v", 32'(s_rspv_a), 32'h4);
    chk("single_rsp_d", 32'(s_rspd_a), 32'h2A5A0);

    // Write then read of the same address on consecutive cycles.
    rv[0] = 1'b1; rwe[0] = 1'b1; raddr[0] = 11'd17; rwd[0] = 18'h1F00F;
    tick();
    chk("wr_grant", 32'(s_rdy), 32'h1);
    rwe[0] = 1'b0;
    tick();
    chk("rd_grant", 32'(s_rdy), 32'h1);
    rv[0] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j == 2) begin
        chk("wr_rd_rsp_v_ll", 32'(s_rspv_b), 32'h1);
        chk("wr_rd_rsp_d_ll", 32'(s_rspd_b), 32'h1F00F);
      end
      if (j == 4) begin
        chk("wr_rd_rsp_v", 32'(s_rspv_a), 32'h1);
        chk("wr_rd_rsp_d", 32'(s_rspd_a), 32'h1F00F);
      end
    end

    // Pointer sits at 2 after a grant to requester 1; then 1 and 3 contend.
    issue(1, 1'b0, 3, '0);
    rv[1] = 1'b1; rwe[1] = 1'b0;
    rv[3] = 1'b1; rwe[3] = 1'b0;
    tick();
    chk("fair_first", 32'(s_rdy), 32'h8);
    rv[3] = 1'b0;
    tick();
    chk("fair_second", 32'(s_rdy), 32'h2);
    rv[1] = 1'b0;
    for (int j = 0; j < 5; j++) tick();

    // Full contention from a fresh pointer.
    do_reset();
    for (int i = 0; i < N; i++) begin
      rv[i] = 1'b1; rwe[i] = 1'b0; raddr[i] = AW'(20 + i);
    end
    for (int j = 0; j < 12; j++) begin
      tick();
      if (j < 8)  chk("contend_grant", 32'(s_rdy), 32'(1 << (j % 4)));
      if (j >= 4) chk("contend_rsp_order", 32'(s_rspv_a), 32'(1 << ((j - 4) % 4)));
      if (j == 7) rv = '0;
    end

    // Reset with three reads in flight.
    rv[1] = 1'b1; rwe[1] = 1'b0;
    for (int j = 0; j < 3; j++) begin
      raddr[1] = AW'(40 + j);
      tick();
      chk("inflight_grant", 32'(s_rdy), 32'h2);
    end
    rv    = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) begin
      tick();
      chk("dropped_rsp_a", 32'(s_rspv_a), 32'd0);
      chk("dropped_rsp_b", 32'(s_rspv_b), 32'd0);
      chk("dropped_busy",  32'(s_busy_a), 32'd0);
    end
    rv = '1;
    tick();
    chk("post_reset_grant", 32'(s_rdy), 32'h1);
    rv = '0;
    for (int j = 0; j < 5; j++) tick();

    // Back-to-back reads on the latency-1 instance.
    for (int i = 0; i < 8; i++) begin
      ll_data[i] = DW'(i * 18'h1357 + 18'h0AB);
      issue(1, 1'b1, i, ll_data[i]);
    end
    rv[1] = 1'b1; rwe[1] = 1'b0; raddr[1] = 11'd0;
    for (int j = 0; j < 10; j++) begin
      tick();
      if (j < 8) begin
        chk("ll_grant", 32'(s_rdy), 32'h2);
        raddr[1] = AW'(j + 1);
        if (j == 7) rv[1] = 1'b0;
      end
      if (j >= 2) begin
        chk("ll_rsp_v", 32'(s_rspv_b), 32'h2);
        chk("ll_rsp_d", 32'(s_rspd_b), 32'(ll_data[j-2]));
      end
    end

    // Random mix with occasional mid-stream resets; the model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      rst_n = !(c == 500 || c == 1000);
      tick();
      for (int i = 0; i < N; i++) begin
        if (!rv[i] || s_rdy[i]) begin
          rv[i]    = ($urandom_range(0, 99) < 60);
          rwe[i]   = ($urandom_range(0, 99) < 40);
          raddr[i] = AW'($urandom_range(0, 15));
          rwd[i]   = DW'($urandom);
        end
      end
    end
    rst_n = 1'b1;
    rv    = '0;
    for (int j = 0; j < 8; j++) tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
